// File: rtl/mscell_ctrl.sv
// mscell_ctrl: sequencer and bit collector for one metastable-state entropy cell.
//   Drives the cell's sampling-enable selects from the mode captured at word
//   start, waits SETTLE_CYCLES clocks, samples the synchronized cell output,
//   optionally von-Neumann debiases, and packs WIDTH bits into a word offered
//   on a valid/ready handshake.
// Ports:
//   i_clk, i_rst_n         clock, async active-low reset
//   i_en                   run (1) / stop-abort (0)
//   i_mode, i_vn_en        sampling config and debias enable, captured at word start
//   i_ms_y                 raw cell output (asynchronous)
//   o_en_samp_in0/in1/out  registered enable selects to the cell
//   o_data_out/o_data_valid/i_data_ready  word handshake
//   o_busy                 not IDLE
//   o_vn_discards          saturating count of discarded equal pairs this word
module mscell_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [1:0]       i_mode,
  input  logic             i_vn_en,
  input  logic             i_ms_y,
  output logic             o_en_samp_in0,
  output logic             o_en_samp_in1,
  output logic             o_en_samp_out,
  output logic [WIDTH-1:0] o_data_out,
  output logic             o_data_valid,
  input  logic             i_data_ready,
  output logic             o_busy,
  output logic [7:0]       o_vn_discards
);

  localparam int BCW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_SAMPLE, S_FULL} state_t;

  state_t           r_state, w_state_nxt;
  logic             r_ys1, r_ys2;
  logic [1:0]       r_mode;
  logic             r_vn;
  logic [CNT_W-1:0] r_cnt;
  logic [BCW-1:0]   r_bits;
  logic [WIDTH-1:0] r_shift, r_data;
  logic             r_valid;
  logic             r_p0, r_ph;
  logic [7:0]       r_disc;
  logic [2:0]       r_ens;

  logic             w_start;     // word start: capture mode/vn_en, clear counters
  logic             w_shift_en;  // a kept bit enters the shift register this cycle
  logic             w_bit;
  logic [1:0]       w_mode_nxt;
  logic [2:0]       w_ens_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_shift_en  = 1'b0;
    w_bit       = r_ys2;
    case (r_state)
      S_IDLE:
        if (i_en) begin
          w_start     = 1'b1;
          w_state_nxt = S_SETTLE;
        end
      S_SETTLE:
        if (!i_en)                                  w_state_nxt = S_IDLE;
        else if (r_cnt == CNT_W'(SETTLE_CYCLES-1))  w_state_nxt = S_SAMPLE;
      S_SAMPLE:
        if (!i_en) w_state_nxt = S_IDLE;
        else begin
          if (!r_vn) w_shift_en = 1'b1;
          else if (r_ph && (r_p0 != r_ys2)) begin
            // 01 -> 0, 10 -> 1: the kept bit is the first of the pair
            w_shift_en = 1'b1;
            w_bit      = r_p0;
          end
          w_state_nxt = (w_shift_en && r_bits == BCW'(WIDTH-1)) ? S_FULL : S_SETTLE;
        end
      S_FULL:
        if (r_valid && i_data_ready) begin
          if (i_en) begin
            w_start     = 1'b1;
            w_state_nxt = S_SETTLE;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Enables follow the mode that will be in effect after this edge, so they
  // switch together with the state that uses them.
  assign w_mode_nxt = w_start ? i_mode : r_mode;

  always_comb begin
    w_ens_nxt = 3'b000;
    if (w_state_nxt != S_IDLE) begin
      case (w_mode_nxt)
        2'b01:   w_ens_nxt = 3'b110;
        2'b10:   w_ens_nxt = 3'b001;
        2'b11:   w_ens_nxt = 3'b111;
        default: w_ens_nxt = 3'b000;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_ys1   <= 1'b0;
      r_ys2   <= 1'b0;
      r_mode  <= 2'b00;
      r_vn    <= 1'b0;
      r_cnt   <= '0;
      r_bits  <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_p0    <= 1'b0;
      r_ph    <= 1'b0;
      r_disc  <= 8'd0;
      r_ens   <= 3'b000;
    end else begin
      r_state <= w_state_nxt;
      r_ys1   <= i_ms_y;
      r_ys2   <= r_ys1;
      r_ens   <= w_ens_nxt;
      r_cnt   <= (r_state == S_SETTLE && w_state_nxt == S_SETTLE) ? r_cnt + CNT_W'(1) : '0;

      if (w_start) begin
        r_mode <= i_mode;
        r_vn   <= i_vn_en;
        r_bits <= '0;
        r_disc <= 8'd0;
        r_ph   <= 1'b0;
      end

      if (r_state == S_SAMPLE && i_en && r_vn) begin
        if (!r_ph) begin
          r_p0 <= r_ys2;
          r_ph <= 1'b1;
        end else begin
          r_ph <= 1'b0;
          if (r_p0 == r_ys2 && r_disc != 8'hFF) r_disc <= r_disc + 8'd1;
        end
      end

      if (w_shift_en) begin
        r_shift <= {r_shift[WIDTH-2:0], w_bit};
        r_bits  <= r_bits + BCW'(1);
      end

      if (w_state_nxt == S_FULL && r_state != S_FULL) begin
        r_data  <= {r_shift[WIDTH-2:0], w_bit};
        r_valid <= 1'b1;
      end else if (r_state == S_FULL && r_valid && i_data_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign {o_en_samp_in0, o_en_samp_in1, o_en_samp_out} = r_ens;
  assign o_data_out    = r_data;
  assign o_data_valid  = r_valid;
  assign o_busy        = (r_state != S_IDLE);
  assign o_vn_discards = r_disc;

endmodule

// File: tb/tb_mscell_ctrl.sv
// tb_mscell_ctrl: randomized bench for mscell_ctrl. Each cell bit is held on
// ms_y for a whole bit period; a word-level model derives the expected word,
// discard count and completion time from the raw bit list.
module tb_mscell_ctrl;
  localparam int WIDTH = 8;
  localparam int SETTLE = 4;
  localparam int PERIOD = SETTLE + 1;

  logic             clk = 1'b0, rst_n = 1'b0;
  logic             en = 1'b0, vn_en = 1'b0, ms_y = 1'b0, data_ready = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic             e_in0, e_in1, e_out, data_valid, busy;
  logic [WIDTH-1:0] data_out;
  logic [7:0]       vn_discards;
  int               n_chk = 0, n_err = 0;

  mscell_ctrl #(.WIDTH(WIDTH), .SETTLE_CYCLES(SETTLE), .CNT_W(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en), .i_mode(mode), .i_vn_en(vn_en),
    .i_ms_y(ms_y), .o_en_samp_in0(e_in0), .o_en_samp_in1(e_in1),
    .o_en_samp_out(e_out), .o_data_out(data_out), .o_data_valid(data_valid),
    .i_data_ready(data_ready), .o_busy(busy), .o_vn_discards(vn_discards));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] ens_of(input logic [1:0] m);
    case (m)
      2'b01:   return 3'b110;
      2'b10:   return 3'b001;
      2'b11:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  // kind 0: random; 1: all ones; 2: pairs 01,10,11,00,10 repeating;
  // 3: 260 equal pairs (saturate discards) then 10 pairs
  function automatic logic next_bit(input int kind, input int idx);
    logic [9:0] pat;
    pat = 10'b0110110010;
    case (kind)
      1:       return 1'b1;
      2:       return pat[9 - (idx % 10)];
      3:       return (idx < 520) ? 1'b1 : ((idx % 2) == 0);
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  function automatic logic [31:0] outs_all();
    return {16'd0, vn_discards, e_in0, e_in1, e_out, data_valid, busy, 3'd0} | 32'(data_out);
  endfunction

  // Called at a negedge with the DUT idle (from_full=0) or holding a word
  // (from_full=1). Collects one word; abort_at/rst_at >= 0 cut it short once
  // that many bits have been kept. Returns at a negedge with the word held.
  task automatic collect(input logic [1:0] md, input logic vn, input int kind,
                         input int hold, input logic from_full,
                         input int abort_at, input int rst_at);
    logic [WIDTH-1:0] w = '0;
    int kept = 0, disc = 0, j = 0;
    logic have_p0 = 1'b0, p0 = 1'b0, b;
    mode = md; vn_en = vn; en = 1'b1;
    if (from_full) data_ready = 1'b1;
    b = next_bit(kind, 0);
    ms_y = b;
    @(posedge clk); @(negedge clk);
    data_ready = 1'b0;
    mode = 2'($urandom);  // must not affect the word in progress
    vn_en = 1'($urandom);
    chk("start_ens", 32'({e_in0, e_in1, e_out}), 32'(ens_of(md)));
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_valid", 32'(data_valid), 32'd0);
    chk("start_disc", 32'(vn_discards), 32'd0);
    while (kept < WIDTH) begin
      if (j >= 3000) begin
        chk("raw_budget", 32'(j), 32'd0);
        return;
      end
      repeat (PERIOD - 1) @(posedge clk);
      @(negedge clk);
      if (rst_at >= 0 && kept == rst_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_outs", outs_all(), 32'd0);
        en = 1'b0;
        @(negedge clk);
        chk("rst_hold", outs_all(), 32'd0);
        rst_n = 1'b1;
        return;
      end
      chk("collect_valid", 32'(data_valid), 32'd0);
      @(posedge clk); @(negedge clk);
      if (!vn) begin
        w = (w << 1) | WIDTH'(b); kept++;
      end else if (!have_p0) begin
        p0 = b; have_p0 = 1'b1;
      end else begin
        have_p0 = 1'b0;
        if (p0 != b) begin
          w = (w << 1) | WIDTH'(p0); kept++;
        end else if (disc < 255) disc++;
      end
      j++;
      if (abort_at >= 0 && kept == abort_at) begin
        en = 1'b0;
        @(posedge clk); @(negedge clk);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ens", 32'({e_in0, e_in1, e_out}), 32'd0);
        repeat (PERIOD * WIDTH) @(posedge clk);
        @(negedge clk);
        chk("abort_valid", 32'(data_valid), 32'd0);
        return;
      end
      if (kept < WIDTH) begin
        b = next_bit(kind, j);
        ms_y = b;
        data_ready = 1'($urandom);  // ignored while no word is held
      end
    end
    data_ready = 1'b0;
    chk("full_valid", 32'(data_valid), 32'd1);
    chk("full_data", 32'(data_out), 32'(w));
    chk("full_disc", 32'(vn_discards), 32'(disc));
    chk("full_ens", 32'({e_in0, e_in1, e_out}), 32'(ens_of(md)));
    if ($urandom_range(0, 1) == 1) en = 1'b0;
    for (int k = 0; k < hold; k++) begin
      @(posedge clk); @(negedge clk);
      mode = 2'($urandom);
      ms_y = 1'($urandom);
    end
    chk("hold_valid", 32'(data_valid), 32'd1);
    chk("hold_data", 32'(data_out), 32'(w));
    chk("hold_busy", 32'(busy), 32'd1);
  endtask

  task automatic finish_idle();
    en = 1'b0; data_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    data_ready = 1'b0;
    chk("idle_valid", 32'(data_valid), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_ens", 32'({e_in0, e_in1, e_out}), 32'd0);
  endtask

  initial begin
    #1;
    chk("reset_outs", outs_all(), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      ms_y = ~ms_y;
      data_ready = 1'($urandom);
      mode = 2'($urandom);
      @(negedge clk);
    end
    chk("idle_outs", outs_all(), 32'd0);
    data_ready = 1'b0;

    collect(2'b01, 1'b0, 1, 3, 1'b0, -1, -1);
    finish_idle();
    collect(2'b01, 1'b1, 2, 20, 1'b0, -1, -1);
    for (int k = 0; k < 6; k++)
      collect(2'($urandom), 1'($urandom), 0, $urandom_range(0, 5), 1'b1, -1, -1);
    finish_idle();

    collect(2'b10, 1'b0, 0, 0, 1'b0, 3, -1);
    collect(2'b10, 1'b0, 1, 2, 1'b0, -1, -1);
    finish_idle();

    collect(2'b11, 1'b1, 3, 2, 1'b0, -1, -1);
    finish_idle();

    collect(2'b01, 1'b1, 0, 0, 1'b0, -1, 3);
    @(negedge clk);
    collect(2'b01, 1'b0, 1, 2, 1'b0, -1, -1);
    finish_idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
